// File: rtl/armleocpu_regfile_sb.sv
// armleocpu_regfile_sb: integer register file with N combinational read ports,
// a single-cycle write port (W0), a late-result write port (W1) and a per-register
// busy scoreboard. Issue reserves late destinations; W1 writeback releases them.
module armleocpu_regfile_sb #(
  parameter int XLEN       = 32,
  parameter int REG_COUNT  = 32,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [READ_PORTS*AW-1:0]     rs_addr,
  output logic [READ_PORTS*XLEN-1:0]   rs_rdata,
  output logic [READ_PORTS-1:0]        rs_busy,
  input  logic                         w0_write,
  input  logic [AW-1:0]                w0_addr,
  input  logic [XLEN-1:0]              w0_wdata,
  input  logic                         w1_write,
  input  logic [AW-1:0]                w1_addr,
  input  logic [XLEN-1:0]              w1_wdata,
  input  logic                         res_valid,
  input  logic [AW-1:0]                res_addr,
  output logic                         res_ready,
  output logic [REG_COUNT-1:0]         busy_vec,
  output logic                         err
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [XLEN-1:0]      regs [REG_COUNT];
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_nxt;
  logic                 err_q;
  logic                 err_set;

  // Writes to the hardwired zero register are dropped before they touch any state.
  logic w0_en;
  logic w1_en;
  logic res_fire;
  logic res_en;

  assign w0_en = w0_write && !(HAS_ZERO && (w0_addr == '0));
  assign w1_en = w1_write && !(HAS_ZERO && (w1_addr == '0));

  // A pending register only accepts a new reservation when its late result lands
  // this very cycle; this keeps two late writes to one register from overlapping.
  assign res_ready = !busy[res_addr] || (w1_write && (w1_addr == res_addr));
  assign res_fire  = res_valid && res_ready;
  assign res_en    = res_fire && !(HAS_ZERO && (res_addr == '0));

  // Protocol errors: a late write nobody reserved, or both ports hitting one register.
  assign err_set = (w1_en && !busy[w1_addr]) ||
                   (w0_en && w1_en && (w0_addr == w1_addr));

  // Next scoreboard: W1 releases, a reservation in the same cycle re-claims and wins.
  always_comb begin
    busy_nxt = busy;
    if (w1_en) busy_nxt[w1_addr] = 1'b0;
    if (res_en) busy_nxt[res_addr] = 1'b1;
  end

  // Register array update; W0 is applied last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      if (w1_en) regs[w1_addr] <= w1_wdata;
      if (w0_en) regs[w0_addr] <= w0_wdata;
    end
  end

  // Scoreboard and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      err_q <= 1'b0;
    end else begin
      busy  <= busy_nxt;
      err_q <= err_q | err_set;
    end
  end

  assign busy_vec = busy;
  assign err      = err_q;

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic            a_zero;
    logic [XLEN-1:0] rd;

    assign a      = rs_addr[k*AW +: AW];
    assign a_zero = HAS_ZERO && (a == '0);

    // Read mux with same-cycle forwarding: zero reg, then W0, then W1, then array.
    always_comb begin
      rd = regs[a];
      if (a_zero) rd = '0;
      else if (w0_write && (w0_addr == a)) rd = w0_wdata;
      else if (w1_write && (w1_addr == a)) rd = w1_wdata;
    end

    assign rs_rdata[k*XLEN +: XLEN] = rd;
    // A late result arriving this cycle already satisfies the reader.
    assign rs_busy[k] = !a_zero && busy[a] && !(w1_write && (w1_addr == a));
  end

endmodule

// File: doc/armleocpu_regfile_sb.md
# armleocpu_regfile_sb

Parametrised integer register file with N combinational read ports, two write ports and a per-register busy scoreboard. Sits between decode/issue and writeback of the ArmleoCPU core. Port W0 carries single-cycle results; port W1 carries late results (loads, multi-cycle ops). The scoreboard lets issue reserve a destination for a late result and stall readers until that result arrives. Same-cycle write data is forwarded to the read ports.

## Interface
- XLEN, 32, register width in bits
- REG_COUNT, 32, number of registers; power of two, ≥2; AW = $clog2(REG_COUNT)
- READ_PORTS, 2, number of read ports, ≥1
- ZERO_REG, 1, 1: register 0 is hardwired to zero and never busy; 0: register 0 is ordinary
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rs_addr  in  READ_PORTS*AW  read addresses; port k occupies bits [k*AW +: AW]
- rs_rdata  out  READ_PORTS*XLEN  read data, port k at [k*XLEN +: XLEN]
- rs_busy  out  READ_PORTS  port k's register has a pending late write
- w0_write  in  1  W0 write enable
- w0_addr  in  AW  W0 address
- w0_wdata  in  XLEN  W0 data
- w1_write  in  1  W1 (late) write enable; clears the busy bit
- w1_addr  in  AW  W1 address
- w1_wdata  in  XLEN  W1 data
- res_valid  in  1  reservation request
- res_addr  in  AW  register to mark busy
- res_ready  out  1  reservation can be accepted this cycle
- busy_vec  out  REG_COUNT  current scoreboard, registered
- err  out  1  sticky protocol-error flag

## Operation
- State: regs[REG_COUNT] of XLEN bits, busy[REG_COUNT], err.
- Reset (rst=1 at the edge): all regs = 0, busy = 0, err = 0. Writes and reservations in that cycle are ignored.
- Writes:
  - W0 writes regs[w0_addr] when w0_write.
  - W1 writes regs[w1_addr] and clears busy[w1_addr] when w1_write.
  - With ZERO_REG=1, writes to address 0 are dropped and do not flag err.
- Same-address W0/W1 write in the same cycle: W0 data wins, busy is still cleared, err is set.
- W1 write to a non-busy register: the data is written and err is set.
- Reads are combinational, in priority order:
  - ZERO_REG && addr==0 → 0.
  - Else W0 hit (w0_write && w0_addr==addr) → w0_wdata.
  - Else W1 hit → w1_wdata.
  - Else regs[addr].
- rs_busy[k] = busy[addr_k] && !(w1_write && w1_addr==addr_k). Always 0 for address 0 when ZERO_REG.
- Reservation readiness: res_ready = !busy[res_addr] || (w1_write && w1_addr==res_addr). This refuses WAW on a pending register.
- Reservation handshake: on res_valid && res_ready, busy[res_addr] is set.
  - If a W1 clear hits the same register in the same cycle, the set wins and the bit stays 1.
  - With ZERO_REG, reserving register 0 is accepted and has no effect.
- res_valid && !res_ready: no state change. The requester holds its request.
- err clears only on rst.

## Timing
- Read latency is 0 cycles, combinational from rs_addr and the write ports.
- A W0/W1 write is visible through bypass in the same cycle and from the array from the next cycle.
- The busy set from a reservation is visible on busy_vec and rs_busy from the cycle after the handshake.
- A busy clear from W1 is visible on rs_busy in the same cycle (combinational) and on busy_vec in the next cycle.
- res_ready depends combinationally on res_addr, w1_write and w1_addr only. It has no path from res_valid.
- All outputs after reset:
  - rs_rdata = 0 for any address.
  - rs_busy = 0, busy_vec = 0, err = 0.
  - res_ready = 1.
- Reset asserted mid-reservation or mid-write: all in-flight effects are discarded.

## Test plan
- Reset, then W0 writes 0xDEADBEEF to x5. Reading x5 on port 0 returns 0xDEADBEEF in the write cycle (bypass) and in the following cycle (array). W0 write to x0 → x0 reads 0.
- Reserve x7 → busy_vec[7]=1 next cycle and rs_busy=1 on a port reading x7. A second reserve of x7 sees res_ready=0. W1 writes 0x1234 to x7 → rs_busy=0 and rdata=0x1234 that cycle; busy_vec[7]=0 next cycle.
- Same cycle: W1 writes x9 (busy) while reserve x9 is requested → res_ready=1, the data is written, and busy_vec[9] stays 1.
- W0 and W1 both write x3 (0xAAAA / 0x5555) → x3 reads 0xAAAA, busy[3] is cleared, err=1 and stays 1 until rst.
- W1 write to a non-busy x4 → the data is written and err=1. Then assert rst while x4 is reserved → all regs read 0, busy_vec=0, err=0.
- READ_PORTS=3, REG_COUNT=16: three ports read x1, x2, x15 simultaneously and return the correct values, with bypass on each port independently.
